// File: rtl/uart_neopixel_phy.sv
// uart_neopixel_phy
//
// Physical layer for the PMOD NeoPixel board. Two independent engines share
// one clock and nothing else:
//   - an 8N1 UART receiver that delivers colour bytes from the host;
//   - a WS2812 serializer that shifts one 24-bit GRB word onto the LED data
//     line per accepted request.
// The surrounding controller stores bytes, sequences pixels and produces
// the inter-frame latch gap; this block never inserts one.
//
// Ports:
//   CLK          system clock, rising edge
//   RST_N        asynchronous active-low reset
//   RX           UART serial input, idles high, asynchronous to CLK
//   o_rx_byte    last correctly framed received byte
//   o_rx_valid   one-cycle pulse when o_rx_byte updates
//   i_pix_valid  pixel write request (accepted while o_pix_busy is low)
//   i_red        red value
//   i_green      green value
//   i_blue       blue value
//   o_pix_data   WS2812 data line
//   o_pix_busy   high while a pixel word is being shifted out

module uart_neopixel_phy #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned BIT_CYC      = 15,
    parameter int unsigned T0H_CYC      = 4,
    parameter int unsigned T1H_CYC      = 9
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       RX,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_valid,
    input  logic       i_pix_valid,
    input  logic [7:0] i_red,
    input  logic [7:0] i_green,
    input  logic [7:0] i_blue,
    output logic       o_pix_data,
    output logic       o_pix_busy
);

    // ------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------
    localparam int unsigned RX_CW = $clog2(CLKS_PER_BIT);
    localparam logic [RX_CW-1:0] RX_HALF_LAST = RX_CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [RX_CW-1:0] RX_FULL_LAST = RX_CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop,
        RxWaitHigh
    } rx_state_e;

    rx_state_e        rx_state_q, rx_state_d;
    logic             rx_meta_q, rx_sync_q;
    logic [RX_CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_idx_q, rx_idx_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic             rx_valid_q, rx_valid_d;

    // Two-flop synchronizer; reset to the idle (high) level so a reset
    // release never looks like a start edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_byte_d  = rx_byte_q;
        rx_valid_d = 1'b0;

        unique case (rx_state_q)
            RxIdle: begin
                if (!rx_sync_q) begin
                    rx_state_d = RxStart;
                    rx_cnt_d   = '0;
                end
            end
            RxStart: begin
                // Re-check at mid start bit; a high line means a glitch.
                if (rx_cnt_q == RX_HALF_LAST) begin
                    rx_cnt_d = '0;
                    if (!rx_sync_q) begin
                        rx_state_d = RxData;
                        rx_idx_d   = '0;
                    end else begin
                        rx_state_d = RxIdle;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RxData: begin
                if (rx_cnt_q == RX_FULL_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};  // LSB first
                    if (rx_idx_q == 3'd7) begin
                        rx_state_d = RxStop;
                    end else begin
                        rx_idx_d = rx_idx_q + 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RxStop: begin
                if (rx_cnt_q == RX_FULL_LAST) begin
                    rx_cnt_d = '0;
                    if (rx_sync_q) begin
                        rx_byte_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                        rx_state_d = RxIdle;
                    end else begin
                        // Framing error: drop the byte and wait for the line
                        // to return high before hunting for a new start bit.
                        rx_state_d = RxWaitHigh;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RxWaitHigh: begin
                if (rx_sync_q) begin
                    rx_state_d = RxIdle;
                end
            end
            default: begin
                rx_state_d = RxIdle;
            end
        endcase
    end

    assign o_rx_byte  = rx_byte_q;
    assign o_rx_valid = rx_valid_q;

    // ------------------------------------------------------------------
    // WS2812 serializer
    // ------------------------------------------------------------------
    localparam int unsigned PX_CW = $clog2(BIT_CYC);
    localparam logic [PX_CW-1:0] PX_BIT_LAST = PX_CW'(BIT_CYC - 1);
    localparam logic [PX_CW-1:0] PX_T0H      = PX_CW'(T0H_CYC);
    localparam logic [PX_CW-1:0] PX_T1H      = PX_CW'(T1H_CYC);

    typedef enum logic {
        PxIdle,
        PxSend
    } px_state_e;

    px_state_e        px_state_q, px_state_d;
    logic [23:0]      px_shift_q, px_shift_d;
    logic [PX_CW-1:0] px_cyc_q, px_cyc_d;
    logic [4:0]       px_idx_q, px_idx_d;
    logic             px_data_q, px_data_d;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            px_state_q <= PxIdle;
            px_shift_q <= '0;
            px_cyc_q   <= '0;
            px_idx_q   <= '0;
            px_data_q  <= 1'b0;
        end else begin
            px_state_q <= px_state_d;
            px_shift_q <= px_shift_d;
            px_cyc_q   <= px_cyc_d;
            px_idx_q   <= px_idx_d;
            px_data_q  <= px_data_d;
        end
    end

    always_comb begin
        px_state_d = px_state_q;
        px_shift_d = px_shift_q;
        px_cyc_d   = px_cyc_q;
        px_idx_d   = px_idx_q;

        unique case (px_state_q)
            PxIdle: begin
                if (i_pix_valid) begin
                    px_state_d = PxSend;
                    px_shift_d = {i_green, i_red, i_blue};
                    px_cyc_d   = '0;
                    px_idx_d   = '0;
                end
            end
            PxSend: begin
                if (px_cyc_q == PX_BIT_LAST) begin
                    px_cyc_d = '0;
                    if (px_idx_q == 5'd23) begin
                        px_state_d = PxIdle;
                    end else begin
                        px_idx_d   = px_idx_q + 1'b1;
                        px_shift_d = {px_shift_q[22:0], 1'b0};
                    end
                end else begin
                    px_cyc_d = px_cyc_q + 1'b1;
                end
            end
            default: begin
                px_state_d = PxIdle;
            end
        endcase

        // Data line is registered from the next-state view so it is
        // glitch-free and rises in the first busy cycle.
        px_data_d = (px_state_d == PxSend) &&
                    (px_cyc_d < (px_shift_d[23] ? PX_T1H : PX_T0H));
    end

    assign o_pix_data = px_data_q;
    assign o_pix_busy = (px_state_q == PxSend);

endmodule

// File: tb/tb_uart_neopixel_phy.sv
module tb_uart_neopixel_phy;

    localparam int unsigned CLKS_PER_BIT = 104;
    localparam int unsigned BIT_CYC      = 15;
    localparam int unsigned T0H_CYC      = 4;
    localparam int unsigned T1H_CYC      = 9;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       RX = 1'b1;
    logic [7:0] o_rx_byte;
    logic       o_rx_valid;
    logic       i_pix_valid = 1'b0;
    logic [7:0] i_red = '0;
    logic [7:0] i_green = '0;
    logic [7:0] i_blue = '0;
    logic       o_pix_data;
    logic       o_pix_busy;

    int errors = 0;
    int checks = 0;

    uart_neopixel_phy #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .BIT_CYC     (BIT_CYC),
        .T0H_CYC     (T0H_CYC),
        .T1H_CYC     (T1H_CYC)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .RX         (RX),
        .o_rx_byte  (o_rx_byte),
        .o_rx_valid (o_rx_valid),
        .i_pix_valid(i_pix_valid),
        .i_red      (i_red),
        .i_green    (i_green),
        .i_blue     (i_blue),
        .o_pix_data (o_pix_data),
        .o_pix_busy (o_pix_busy)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Receive log
    logic [7:0] rx_bytes[$];
    int         rx_times[$];
    always @(negedge CLK) begin
        if (o_rx_valid) begin
            rx_bytes.push_back(o_rx_byte);
            rx_times.push_back(cyc);
        end
    end

    // Pixel line log: length of every high pulse, busy cycles, busy rises
    int   hi_q[$];
    int   run = 0;
    int   busy_cyc = 0;
    int   busy_rises = 0;
    logic busy_prev = 1'b0;
    always @(negedge CLK) begin
        if (o_pix_data) begin
            run = run + 1;
        end else if (run > 0) begin
            hi_q.push_back(run);
            run = 0;
        end
        if (o_pix_busy) busy_cyc = busy_cyc + 1;
        if (o_pix_busy && !busy_prev) busy_rises = busy_rises + 1;
        busy_prev = o_pix_busy;
    end

    task automatic uart_bit(input logic b);
        RX = b;
        repeat (CLKS_PER_BIT) @(negedge CLK);
    endtask

    task automatic uart_send(input logic [7:0] d, input logic stop, output int t0);
        @(negedge CLK);
        t0 = cyc;
        uart_bit(1'b0);
        for (int i = 0; i < 8; i++) uart_bit(d[i]);
        uart_bit(stop);
        RX = 1'b1;
    endtask

    task automatic test_reset;
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if (o_rx_byte !== 8'h00) begin
            errors++; $display("FAIL reset_rx_byte: got %h want 00", o_rx_byte);
        end
        checks++;
        if (o_rx_valid !== 1'b0) begin
            errors++; $display("FAIL reset_rx_valid: got %b want 0", o_rx_valid);
        end
        checks++;
        if (o_pix_data !== 1'b0) begin
            errors++; $display("FAIL reset_pix_data: got %b want 0", o_pix_data);
        end
        checks++;
        if (o_pix_busy !== 1'b0) begin
            errors++; $display("FAIL reset_pix_busy: got %b want 0", o_pix_busy);
        end
        RST_N = 1'b1;
        repeat (5) @(negedge CLK);
    endtask

    task automatic test_uart_back_to_back;
        int base;
        int t0;
        int t1;
        base = rx_bytes.size();
        uart_send(8'hA5, 1'b1, t0);
        uart_send(8'h3C, 1'b1, t1);
        repeat (20) @(negedge CLK);
        checks++;
        if (rx_bytes.size() - base !== 2) begin
            errors++;
            $display("FAIL uart_b2b_count: got %0d want 2", rx_bytes.size() - base);
        end else begin
            checks++;
            if (rx_bytes[base] !== 8'hA5) begin
                errors++; $display("FAIL uart_b2b_byte0: got %h want a5", rx_bytes[base]);
            end
            checks++;
            if (rx_bytes[base+1] !== 8'h3C) begin
                errors++; $display("FAIL uart_b2b_byte1: got %h want 3c", rx_bytes[base+1]);
            end
            // 9.5 +/- 1 bit periods from the start edge
            checks++;
            if (rx_times[base] - t0 < 884 || rx_times[base] - t0 > 1092) begin
                errors++;
                $display("FAIL uart_b2b_lat0: got %0d want 884..1092", rx_times[base] - t0);
            end
            checks++;
            if (rx_times[base+1] - t1 < 884 || rx_times[base+1] - t1 > 1092) begin
                errors++;
                $display("FAIL uart_b2b_lat1: got %0d want 884..1092", rx_times[base+1] - t1);
            end
        end
    endtask

    task automatic test_uart_glitch_framing;
        int base;
        int t0;
        base = rx_bytes.size();
        RX = 1'b0;
        repeat (20) @(negedge CLK);
        RX = 1'b1;
        repeat (300) @(negedge CLK);
        checks++;
        if (rx_bytes.size() !== base) begin
            errors++; $display("FAIL uart_glitch: got %0d pulses want 0", rx_bytes.size() - base);
        end
        uart_send(8'hFF, 1'b0, t0);
        repeat (200) @(negedge CLK);
        checks++;
        if (rx_bytes.size() !== base) begin
            errors++; $display("FAIL uart_framing: got %0d pulses want 0", rx_bytes.size() - base);
        end
        checks++;
        if (o_rx_byte !== 8'h3C) begin
            errors++; $display("FAIL uart_framing_hold: got %h want 3c", o_rx_byte);
        end
        uart_send(8'h11, 1'b1, t0);
        repeat (20) @(negedge CLK);
        checks++;
        if (rx_bytes.size() - base !== 1) begin
            errors++;
            $display("FAIL uart_after_err_count: got %0d want 1", rx_bytes.size() - base);
        end else begin
            checks++;
            if (rx_bytes[base] !== 8'h11) begin
                errors++; $display("FAIL uart_after_err_byte: got %h want 11", rx_bytes[base]);
            end
        end
    endtask

    task automatic test_pixel_single;
        int exp_hi[24] = '{4, 4, 4, 4, 4, 4, 4, 4,
                           4, 9, 4, 4, 4, 4, 4, 4,
                           9, 4, 4, 4, 4, 4, 4, 9};
        int base_hi;
        int base_busy;
        int n;
        base_hi = hi_q.size();
        base_busy = busy_cyc;
        @(negedge CLK);
        i_pix_valid = 1'b1;
        i_red = 8'h40; i_green = 8'h00; i_blue = 8'h81;
        @(negedge CLK);
        checks++;
        if (o_pix_busy !== 1'b1 || o_pix_data !== 1'b1) begin
            errors++;
            $display("FAIL pix_start: got busy=%b data=%b want 1 1", o_pix_busy, o_pix_data);
        end
        i_pix_valid = 1'b0;
        i_red = 8'hFF; i_green = 8'hFF; i_blue = 8'hFF;
        n = 0;
        while (o_pix_busy && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (o_pix_busy !== 1'b0) begin
            errors++; $display("FAIL pix_single_timeout: busy=%b want 0", o_pix_busy);
        end
        repeat (3) @(negedge CLK);
        checks++;
        if (busy_cyc - base_busy !== 360) begin
            errors++; $display("FAIL pix_single_busy: got %0d want 360", busy_cyc - base_busy);
        end
        checks++;
        if (hi_q.size() - base_hi !== 24) begin
            errors++; $display("FAIL pix_single_bits: got %0d want 24", hi_q.size() - base_hi);
        end else begin
            for (int i = 0; i < 24; i++) begin
                checks++;
                if (hi_q[base_hi+i] !== exp_hi[i]) begin
                    errors++;
                    $display("FAIL pix_single_hi[%0d]: got %0d want %0d",
                             i, hi_q[base_hi+i], exp_hi[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [47:0] w;
        int base_hi;
        int base_busy;
        int base_rises;
        int n;
        int want;
        w = {8'h0F, 8'hAA, 8'hF0, 8'h80, 8'h01, 8'h3C};  // {G,R,B} x2
        base_hi = hi_q.size();
        base_busy = busy_cyc;
        base_rises = busy_rises;
        @(negedge CLK);
        i_pix_valid = 1'b1;
        i_red = 8'hAA; i_green = 8'h0F; i_blue = 8'hF0;
        @(negedge CLK);
        checks++;
        if (o_pix_busy !== 1'b1) begin
            errors++; $display("FAIL b2b_start: got busy=%b want 1", o_pix_busy);
        end
        i_red = 8'h01; i_green = 8'h80; i_blue = 8'h3C;
        n = 0;
        while (o_pix_busy && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (o_pix_busy !== 1'b0 || o_pix_data !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: got busy=%b data=%b want 0 0", o_pix_busy, o_pix_data);
        end
        @(negedge CLK);
        checks++;
        if (o_pix_busy !== 1'b1 || o_pix_data !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart: got busy=%b data=%b want 1 1", o_pix_busy, o_pix_data);
        end
        i_pix_valid = 1'b0;
        n = 0;
        while (o_pix_busy && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        repeat (3) @(negedge CLK);
        checks++;
        if (busy_cyc - base_busy !== 720) begin
            errors++; $display("FAIL b2b_busy: got %0d want 720", busy_cyc - base_busy);
        end
        checks++;
        if (busy_rises - base_rises !== 2) begin
            errors++; $display("FAIL b2b_words: got %0d want 2", busy_rises - base_rises);
        end
        checks++;
        if (hi_q.size() - base_hi !== 48) begin
            errors++; $display("FAIL b2b_bits: got %0d want 48", hi_q.size() - base_hi);
        end else begin
            for (int i = 0; i < 48; i++) begin
                want = w[47-i] ? 9 : 4;
                checks++;
                if (hi_q[base_hi+i] !== want) begin
                    errors++;
                    $display("FAIL b2b_hi[%0d]: got %0d want %0d", i, hi_q[base_hi+i], want);
                end
            end
        end
    endtask

    task automatic test_valid_during_busy;
        logic [23:0] w;
        int base_hi;
        int base_busy;
        int base_rises;
        int n;
        int want;
        w = {8'h5A, 8'hC3, 8'h01};
        base_hi = hi_q.size();
        base_busy = busy_cyc;
        base_rises = busy_rises;
        @(negedge CLK);
        i_pix_valid = 1'b1;
        i_red = 8'hC3; i_green = 8'h5A; i_blue = 8'h01;
        @(negedge CLK);
        i_pix_valid = 1'b0;
        for (int k = 0; k < 340; k++) begin
            i_pix_valid = (k % 7 == 3);
            i_red = 8'($urandom); i_green = 8'($urandom); i_blue = 8'($urandom);
            @(negedge CLK);
        end
        i_pix_valid = 1'b0;
        n = 0;
        while (o_pix_busy && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        repeat (20) @(negedge CLK);
        checks++;
        if (busy_rises - base_rises !== 1) begin
            errors++; $display("FAIL vdb_words: got %0d want 1", busy_rises - base_rises);
        end
        checks++;
        if (busy_cyc - base_busy !== 360) begin
            errors++; $display("FAIL vdb_busy: got %0d want 360", busy_cyc - base_busy);
        end
        checks++;
        if (hi_q.size() - base_hi !== 24) begin
            errors++; $display("FAIL vdb_bits: got %0d want 24", hi_q.size() - base_hi);
        end else begin
            for (int i = 0; i < 24; i++) begin
                want = w[23-i] ? 9 : 4;
                checks++;
                if (hi_q[base_hi+i] !== want) begin
                    errors++;
                    $display("FAIL vdb_hi[%0d]: got %0d want %0d", i, hi_q[base_hi+i], want);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        int n;
        int base;
        int t0;
        @(negedge CLK);
        i_pix_valid = 1'b1;
        i_red = 8'hFF; i_green = 8'hFF; i_blue = 8'hFF;
        RX = 1'b0;
        @(negedge CLK);
        i_pix_valid = 1'b0;
        n = 0;
        while ((n < 200 || o_pix_data !== 1'b1) && n < 400) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (o_pix_busy !== 1'b1 || o_pix_data !== 1'b1 || o_rx_byte !== 8'h11) begin
            errors++;
            $display("FAIL rst_mid_pre: got busy=%b data=%b byte=%h want 1 1 11",
                     o_pix_busy, o_pix_data, o_rx_byte);
        end
        #2 RST_N = 1'b0;
        #1;
        checks++;
        if (o_pix_data !== 1'b0 || o_pix_busy !== 1'b0 ||
            o_rx_byte !== 8'h00 || o_rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_async: got data=%b busy=%b byte=%h valid=%b want 0 0 00 0",
                     o_pix_data, o_pix_busy, o_rx_byte, o_rx_valid);
        end
        RX = 1'b1;
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (5) @(negedge CLK);
        checks++;
        if (o_pix_data !== 1'b0 || o_pix_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_release: got data=%b busy=%b want 0 0", o_pix_data, o_pix_busy);
        end
        base = rx_bytes.size();
        uart_send(8'h5A, 1'b1, t0);
        repeat (20) @(negedge CLK);
        checks++;
        if (rx_bytes.size() - base !== 1) begin
            errors++;
            $display("FAIL rst_mid_rx_count: got %0d want 1", rx_bytes.size() - base);
        end else begin
            checks++;
            if (rx_bytes[base] !== 8'h5A) begin
                errors++; $display("FAIL rst_mid_rx_byte: got %h want 5a", rx_bytes[base]);
            end
        end
        checks++;
        if (o_rx_byte !== 8'h5A) begin
            errors++; $display("FAIL rst_mid_rx_hold: got %h want 5a", o_rx_byte);
        end
    endtask

    initial begin
        test_reset();
        test_uart_back_to_back();
        test_uart_glitch_framing();
        test_pixel_single();
        test_back_to_back();
        test_valid_during_busy();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
